// File: rtl/mode_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mode_seq_pkg: FSM state type, clog2 helper and default mode-code table.   |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
package mode_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } seq_state_e;

  localparam logic [5:0] DEFAULT_MODE_TABLE = {2'b11, 2'b01, 2'b00};

  // Never returns less than 1 so single-value counters still get a real bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) result = result + 1;
    return (result == 0) ? 1 : result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mode_sequencer_debouncer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | button_debouncer: 2-flop synchroniser plus counter debounce with          |
// | rise/fall strobes active in the cycle before the level flips. Rev 1.0     |
// +--------------------------------------------------------------------------+
module button_debouncer
  import mode_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = clog2(DEBOUNCE_CYCLES);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flip;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    flip    = 1'b0;
    // Counter only runs while the synced input disagrees with the level.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        flip    = 1'b1;
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = level_q;
  assign rise = flip & sync2_q;
  assign fall = flip & ~sync2_q;

endmodule
`default_nettype wire

// File: rtl/mode_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mode_sequencer: debounced button steps a table-mapped mode index.         |
// | MODE_SEQ_LONGPRESS_EN adds long-press return-to-home. Revision 1.0        |
// +--------------------------------------------------------------------------+
module mode_sequencer
  import mode_seq_pkg::*;
#(
  parameter int unsigned                   NUM_MODES         = 3,
  parameter int unsigned                   MODE_W            = 2,
  parameter logic [NUM_MODES*MODE_W-1:0]   MODE_TABLE        = DEFAULT_MODE_TABLE,
  parameter int unsigned                   DEBOUNCE_CYCLES   = 250000,
  parameter int unsigned                   LONG_PRESS_CYCLES = 50000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          button,
  input  logic                          lock,
  output logic [MODE_W-1:0]             mode,
  output logic [clog2(NUM_MODES)-1:0]   mode_idx,
  output logic                          mode_changed,
  output logic                          long_press
);

  localparam int unsigned IDX_W = clog2(NUM_MODES);

  logic level, rise, fall;
  logic step_evt, home_evt;

  logic [IDX_W-1:0]  idx_q, idx_d, idx_next;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              pend_q, pend_d;
  logic              mode_changed_q, mode_changed_d;
  logic              long_press_q, long_press_d;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk  (clk),
    .rst  (rst),
    .din  (button),
    .dout (level),
    .rise (rise),
    .fall (fall)
  );

`ifdef MODE_SEQ_LONGPRESS_EN
  localparam int unsigned HOLD_W = clog2(LONG_PRESS_CYCLES);

  seq_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              unused_ok;

  assign unused_ok = level;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    step_evt = 1'b0;
    home_evt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_HELD;
          hold_d  = '0;
        end
      end
      ST_HELD: begin
        // A release on the threshold cycle still counts as a short press.
        if (fall) begin
          step_evt = 1'b1;
          state_d  = ST_IDLE;
        end else if (hold_q == HOLD_W'(LONG_PRESS_CYCLES - 1)) begin
          home_evt = 1'b1;
          state_d  = ST_LONG;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_LONG: begin
        if (fall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end
`else
  logic unused_ok;

  assign step_evt  = rise;
  assign home_evt  = 1'b0;
  assign unused_ok = &{1'b0, fall, level, (LONG_PRESS_CYCLES > 0)};
`endif

  assign idx_next = (idx_q == IDX_W'(NUM_MODES - 1)) ? '0 : idx_q + 1'b1;

  always_comb begin
    idx_d          = idx_q;
    pend_d         = 1'b0;
    long_press_d   = 1'b0;
    mode_changed_d = pend_q;
    // Locked events are dropped outright rather than deferred.
    if (!lock) begin
      if (step_evt) begin
        idx_d  = idx_next;
        pend_d = 1'b1;
      end else if (home_evt) begin
        idx_d        = '0;
        long_press_d = 1'b1;
        pend_d       = (idx_q != '0);
      end
    end
    mode_d = MODE_TABLE[idx_d*MODE_W +: MODE_W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q          <= '0;
      mode_q         <= MODE_TABLE[MODE_W-1:0];
      pend_q         <= 1'b0;
      mode_changed_q <= 1'b0;
      long_press_q   <= 1'b0;
    end else begin
      idx_q          <= idx_d;
      mode_q         <= mode_d;
      pend_q         <= pend_d;
      mode_changed_q <= mode_changed_d;
      long_press_q   <= long_press_d;
    end
  end

  assign mode         = mode_q;
  assign mode_idx     = idx_q;
  assign mode_changed = mode_changed_q;
  assign long_press   = long_press_q;

endmodule
`default_nettype wire

// File: tb/tb_mode_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mode_sequencer: randomized press stimulus with a press-level model     |
// | feeding pulse scoreboards. Revision 1.0                                   |
// +--------------------------------------------------------------------------+
module tb_mode_sequencer;

  localparam int NUM_MODES = 3;
  localparam int MODE_W    = 2;
  localparam int DEB       = 4;
  localparam int LP        = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       button;
  logic       lock;
  logic [1:0] mode;
  logic [1:0] mode_idx;
  logic       mode_changed;
  logic       long_press;

  int checks   = 0;
  int failures = 0;
  int model_idx = 0;
  int exp_mc_q[$];
  int exp_lp_q[$];

  mode_sequencer #(
    .NUM_MODES         (NUM_MODES),
    .MODE_W            (MODE_W),
    .MODE_TABLE        (6'b11_01_00),
    .DEBOUNCE_CYCLES   (DEB),
    .LONG_PRESS_CYCLES (LP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .button       (button),
    .lock         (lock),
    .mode         (mode),
    .mode_idx     (mode_idx),
    .mode_changed (mode_changed),
    .long_press   (long_press)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] code_of(input int i);
    logic [5:0] t;
    t = 6'b11_01_00;
    return t[i*2 +: 2];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Press-level reference: a press is long only when held well past the
  // long-press threshold; everything else is a plain step.
  task automatic model_press(input int hold, input bit lk);
    bit is_long;
    is_long = 1'b0;
`ifdef MODE_SEQ_LONGPRESS_EN
    is_long = (hold >= LP + DEB + 4);
`endif
    if (!lk) begin
      if (is_long) begin
        exp_lp_q.push_back(0);
        if (model_idx != 0) begin
          model_idx = 0;
          exp_mc_q.push_back(0);
        end
      end else begin
        model_idx = (model_idx + 1) % NUM_MODES;
        exp_mc_q.push_back(model_idx);
      end
    end
  endtask

  task automatic check_state(input string nm);
    chk({nm, "_idx"}, mode_idx, model_idx);
    chk({nm, "_mode"}, mode, code_of(model_idx));
  endtask

  task automatic press(input int hold, input bit lk, input string nm);
    lock = lk;
    model_press(hold, lk);
    @(posedge clk); #1 button = 1'b1;
    repeat (hold) @(posedge clk);
    #1 button = 1'b0;
    repeat (12) @(posedge clk);
    #1 lock = 1'b0;
    check_state(nm);
  endtask

  task automatic glitch(input int len);
    @(posedge clk); #1 button = 1'b1;
    repeat (len) @(posedge clk);
    #1 button = 1'b0;
    repeat (10) @(posedge clk);
    #1 check_state("glitch");
  endtask

  // Monitor: every output pulse must match the next expected event.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (mode_changed === 1'b1) begin
          if (exp_mc_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL mc_unexpected actual=1 expected=0 at %0t", $time);
          end else begin
            e = exp_mc_q.pop_front();
            chk("mc_idx", mode_idx, e);
            chk("mc_mode", mode, code_of(e));
          end
        end
        if (long_press === 1'b1) begin
          if (exp_lp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL lp_unexpected actual=1 expected=0 at %0t", $time);
          end else begin
            e = exp_lp_q.pop_front();
            chk("lp_idx", mode_idx, e);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] old_code, new_code;
    rst = 1'b0; button = 1'b0; lock = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mode", mode, 0);
    chk("rst_idx", mode_idx, 0);
    chk("rst_mc", mode_changed, 0);
    chk("rst_lp", long_press, 0);
    @(negedge clk) rst = 1'b1;

    // Exact latency of the first change.
    old_code = code_of(model_idx);
    model_press(8, 1'b0);
    new_code = code_of(model_idx);
    @(posedge clk); #1 button = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
`ifndef MODE_SEQ_LONGPRESS_EN
      if (k == 5) chk("lat_before", mode, old_code);
      if (k == 6) chk("lat_after", mode, new_code);
`endif
    end
    button = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
`ifdef MODE_SEQ_LONGPRESS_EN
      if (k == 5) chk("lat_before", mode, old_code);
      if (k == 6) chk("lat_after", mode, new_code);
`endif
    end
    check_state("timed");

    for (int g = 1; g <= 3; g++) glitch(g);

    // Reset in the middle of a press; the held button then counts as a fresh press.
    @(posedge clk); #1 button = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk); #2 rst = 1'b0;
    #1;
    chk("arst_mode", mode, 0);
    chk("arst_idx", mode_idx, 0);
    chk("arst_mc", mode_changed, 0);
    chk("arst_lp", long_press, 0);
    model_idx = 0;
    exp_mc_q.delete();
    exp_lp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    model_press(8, 1'b0);
    repeat (8) @(posedge clk);
    #1 button = 1'b0;
    repeat (12) @(posedge clk);
    #1 check_state("post_rst");

    for (int i = 0; i < 3; i++) press(8, 1'b0, "wrap");

    press(7, 1'b1, "lock");
    press(9, 1'b1, "lock");
    press(8, 1'b0, "unlock");

    while (model_idx != 2) press(6, 1'b0, "to_two");
    press(30, 1'b0, "long");
    press(30, 1'b0, "long_at_zero");

    for (int i = 0; i < 24; i++) begin
      int hold;
      bit lk;
      hold = ($urandom_range(0, 2) == 0) ? $urandom_range(25, 35) : $urandom_range(6, 10);
      lk = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) glitch($urandom_range(1, 3));
      press(hold, lk, "rand");
    end

    repeat (10) @(posedge clk);
    chk("mc_queue_empty", exp_mc_q.size(), 0);
    chk("lp_queue_empty", exp_lp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
